bar_pattern_gen: RTL and testbench
==================================

Name: bar_pattern_gen

Overview:
Parametrised colour-bar test-pattern generator for the VGA output path. It supports N bars and several display modes: vertical, horizontal, checkerboard, and horizontally scrolling bars. Bar and gap positions come from incremental per-axis trackers, so no divider is needed. It sits between the VGA timing generator (x, y, disp_en) and the top-level RGB mux, and produces one registered pixel per VGA_CLK.

Parameters:
H, 1280, visible pixels per line
V, 1024, visible lines per frame
NBARS, 3, number of bars per axis (2..8)
BAR_W, 415, bar width in pixels (vertical/checker/scroll modes)
BAR_H, 335, bar height in lines (horizontal/checker modes)
GAP, 5, black gap before each bar, in pixels/lines
SCROLL_STEP, 4, pixels the pattern advances per frame in scroll mode (1..BAR_W)

Ports:
VGA_CLK  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high
disp_en  in  1  visible-area flag from timing generator
x  in  11  current pixel column
y  in  11  current line
mode_sel  in  2  0 vertical bars, 1 horizontal bars, 2 checkerboard, 3 scrolling vertical bars
scroll_en  in  1  enables offset advance in mode 3
r  out  8  red
g  out  8  green
b  out  8  blue

Behaviour:
- Clock and reset: one clock (VGA_CLK). Reset is synchronous and active-high.
- Reset values: r, g, b = 0; latched mode = 0; scroll offset = 0; trackers cleared.
- Latency: r/g/b at cycle t+1 reflect x, y, disp_en at cycle t. Fixed at 1 cycle in all modes.
- Blanking: disp_en = 0 gives r = g = b = 0 on the next cycle, whatever the mode.
- Period: S = GAP + BAR_W horizontally, SV = GAP + BAR_H vertically. PH = NBARS*S and PV = NBARS*SV.
- Axis position: p = x in modes 0 and 2; p = (x + offset) mod PH in mode 3. Vertical position q = y.
- Bar index: i = p div S; in-period position u = p mod S.
  - Pixel is a bar pixel of index i when u >= GAP and p < PH.
  - Otherwise (gap, or p >= PH in modes 0/2) it is black.
  - The same rule applies vertically with q, SV, PV.
- Tracker: an incremental (bar index, in-period counter) pair per axis.
  - Loaded at x == 0 (or y == 0) from the offset pair.
  - Advances by 1 per pixel and wraps the counter at S and the index at NBARS.
  - No multiply or divide on the pixel path.
- Colour per mode:
  - Modes 0 and 3: palette[i].
  - Mode 1: palette[j] for vertical index j; the x gap is ignored.
  - Mode 2: palette[(i + j) mod 8], black if either axis is in a gap or beyond its period.
- Palette (index: r,g,b):
  - 0: FF,00,00
  - 1: 00,FF,00
  - 2: 00,00,FF
  - 3: FF,FF,00
  - 4: 00,FF,FF
  - 5: FF,00,FF
  - 6: FF,FF,FF
  - 7: 80,80,80
- Frame boundary: the cycle with x == H-1, y == V-1 and disp_en == 1.
  - On that cycle mode_sel is latched.
  - If the newly latched mode is 3 and scroll_en = 1, offset advances by SCROLL_STEP mod PH.
  - Both changes take effect from pixel (0,0) of the next frame.
  - mode_sel or scroll_en changes mid-frame have no visible effect until then.
- Offset is held as an (index, counter) pair and wraps modulo PH without a divide.
- Offset is held unchanged in modes 0–2 and while scroll_en = 0.
- Reset mid-frame: outputs are black the next cycle. The pattern resumes with mode 0 and offset 0 at the next x == 0 reload.
- Out-of-range coordinates (x >= H or y >= V with disp_en = 1) are output as black.

Decomposition:
- Package bar_pattern_pkg holds:
  - mode encoding constants: MODE_VBAR = 0, MODE_HBAR = 1, MODE_CHECK = 2, MODE_SCROLL = 3;
  - the 8-entry palette constants;
  - the colour-depth constants full = 8'hFF and empty = 8'h00.
- One sub-module, bar_axis_tracker, with parameters SEG = S or SV, COUNT = NBARS, GAP.
  - Inputs: load, load_idx, load_cnt, advance.
  - Outputs: idx, in_gap, beyond.
  - Instantiated once for x and once for y. The scroll offset reuses its wrap logic.

Test Plan:
1. Mode 0, defaults, sweep x at y = 10 -> black at x = 0..4, red at 5..419, black at 420..424, green at 425..839, blue at 845..1259, black at 1260..1279; each output one cycle after its x.
2. Mode 0, disp_en = 0 at x = 100 -> r/g/b = 00,00,00 next cycle; then disp_en = 1 at x = 101 -> red.
3. Mode 1, sweep y at x = 600 -> black at y = 0..4, red at 5..339, green at 345..679, blue at 685..1019, black at 1020..1023.
4. Mode 3, scroll_en = 1, after 2 frame boundaries (offset 8):
   - x = 0 -> p = 8, red;
   - x = 1255 -> p = 3, black;
   - after 315 boundaries the offset is back to 0 and x = 4 is black.
5. Mode 2, defaults: (x = 500, y = 500) -> i = 1, j = 1 -> palette[2] blue; (x = 10, y = 2) -> black (y in gap).
6. mode_sel 0→1 at y = 500, then reset pulse at y = 700 -> no change before reset; black the cycle after reset; mode 0 bars with offset 0 from the next line; mode 1 only after the following frame boundary.

Source files
------------

// File: rtl/bar_pattern_pkg.sv
// bar_pattern_pkg: mode encodings, palette and the shared modular position step
package bar_pattern_pkg;
  localparam logic [1:0] MODE_VBAR = 2'd0;
  localparam logic [1:0] MODE_HBAR = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SCROLL = 2'd3;
  localparam logic [7:0] full = 8'hFF;
  localparam logic [7:0] empty = 8'h00;
  localparam int CW = 11;
  localparam int IW = 3;
  localparam logic [23:0] PALETTE [8] = '{
    {full, empty, empty},
    {empty, full, empty},
    {empty, empty, full},
    {full, full, empty},
    {empty, full, full},
    {full, empty, full},
    {full, full, full},
    {8'h80, 8'h80, 8'h80}
  };
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
  } pos_t;
  // Advance an (index, counter) pair by step (< seg); the counter wraps at seg and
  // carries into the index, which wraps after last. One subtract, no divide.
  function automatic pos_t pos_step(pos_t p, logic [CW-1:0] step, logic [CW-1:0] seg,
                                    logic [IW-1:0] last);
    logic [CW:0] sum;
    logic over;
    pos_t n;
    sum = {1'b0, p.cnt} + {1'b0, step};
    over = sum >= {1'b0, seg};
    n.cnt = over ? CW'(sum - {1'b0, seg}) : sum[CW-1:0];
    n.idx = !over ? p.idx : p.idx == last ? '0 : p.idx + 1'b1;
    return n;
  endfunction
endpackage

// File: rtl/bar_axis_tracker.sv
// bar_axis_tracker: incremental bar index / in-period position along one axis
module bar_axis_tracker
  import bar_pattern_pkg::*;
#(
  parameter int SEG = 420,
  parameter int COUNT = 3,
  parameter int GAP = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic [CW-1:0] load_cnt,
  input  logic          advance,
  output logic [IW-1:0] idx,
  output logic          in_gap,
  output logic          beyond
);
  localparam logic [IW-1:0] LAST = IW'(COUNT - 1);
  pos_t pos_q, pos_d, nxt;
  logic beyond_q, beyond_d;
  // Position of the current pixel: reload, one step past the previous pixel, or hold.
  // beyond latches once the index has wrapped past the last bar since the reload.
  always_comb begin
    nxt = pos_step(pos_q, CW'(1), CW'(SEG), LAST);
    pos_d = load ? pos_t'({load_idx, load_cnt}) : advance ? nxt : pos_q;
    beyond_d = !load && (beyond_q || (advance && pos_q.idx == LAST && nxt.idx == '0));
  end
  // Remember the current pixel's position for the next step
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      beyond_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      beyond_q <= beyond_d;
    end
  end
  assign idx = pos_d.idx;
  assign in_gap = pos_d.cnt < CW'(GAP);
  assign beyond = beyond_d;
endmodule

// File: rtl/bar_pattern_gen.sv
// bar_pattern_gen: colour-bar test pattern with vertical, horizontal, checker and scroll modes
module bar_pattern_gen
  import bar_pattern_pkg::*;
#(
  parameter int H = 1280,
  parameter int V = 1024,
  parameter int NBARS = 3,
  parameter int BAR_W = 415,
  parameter int BAR_H = 335,
  parameter int GAP = 5,
  parameter int SCROLL_STEP = 4
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        disp_en,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [1:0]  mode_sel,
  input  logic        scroll_en,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);
  localparam int S = GAP + BAR_W;
  localparam int SV = GAP + BAR_H;
  logic [1:0] mode_q, mode_d;
  pos_t off_q, off_d, off_nxt, x_load;
  logic [10:0] x_prev_q, y_prev_q;
  logic synced_q, synced_d, frame_end, blk;
  logic [23:0] rgb_q, rgb_d;
  logic [IW-1:0] xi, yi, ci;
  logic xg, xb, yg, yb;

  bar_axis_tracker #(.SEG(S), .COUNT(NBARS), .GAP(GAP)) u_x (
    .clk(VGA_CLK), .rst(reset), .load(x == '0), .load_idx(x_load.idx), .load_cnt(x_load.cnt),
    .advance(x != x_prev_q), .idx(xi), .in_gap(xg), .beyond(xb)
  );

  bar_axis_tracker #(.SEG(SV), .COUNT(NBARS), .GAP(GAP)) u_y (
    .clk(VGA_CLK), .rst(reset), .load(y == '0), .load_idx('0), .load_cnt('0),
    .advance(y != y_prev_q), .idx(yi), .in_gap(yg), .beyond(yb)
  );

  // Mode and scroll offset change only at the last visible pixel of a frame;
  // synced stays low after reset until the x tracker has been reloaded at x == 0
  always_comb begin
    frame_end = disp_en && x == 11'(H - 1) && y == 11'(V - 1);
    off_nxt = pos_step(off_q, CW'(SCROLL_STEP), CW'(S), IW'(NBARS - 1));
    mode_d = frame_end ? mode_sel : mode_q;
    off_d = frame_end && mode_sel == MODE_SCROLL && scroll_en ? off_nxt : off_q;
    x_load = mode_q == MODE_SCROLL ? off_q : '0;
    synced_d = synced_q || x == '0;
  end

  // Colour for the current pixel; scroll mode wraps modulo the pattern, so it ignores beyond
  always_comb begin
    ci = mode_q == MODE_HBAR ? yi : mode_q == MODE_CHECK ? xi + yi : xi;
    blk = mode_q == MODE_HBAR ? (yg || yb) :
          mode_q == MODE_CHECK ? (xg || xb || yg || yb) :
          mode_q == MODE_SCROLL ? xg : (xg || xb);
    rgb_d = disp_en && synced_d && x < 11'(H) && y < 11'(V) && !blk ? PALETTE[ci]
                                                                   : {empty, empty, empty};
  end

  // Register pixel, latched mode, offset and coordinate history
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      mode_q <= MODE_VBAR;
      off_q <= '0;
      synced_q <= 1'b0;
      rgb_q <= '0;
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      mode_q <= mode_d;
      off_q <= off_d;
      synced_q <= synced_d;
      rgb_q <= rgb_d;
      x_prev_q <= x;
      y_prev_q <= y;
    end
  end

  assign {r, g, b} = rgb_q;
endmodule

// File: tb/tb_bar_pattern_gen.sv
// tb_bar_pattern_gen: directed scenario tests for bar_pattern_gen
module tb_bar_pattern_gen;
  logic clk = 1'b0;
  logic reset = 1'b1, disp_en = 1'b0, scroll_en = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic [1:0] mode_sel = 2'd0;
  logic [7:0] r, g, b;
  int checks = 0, errors = 0;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE = 24'h0000FF;
  localparam logic [23:0] CYAN = 24'h00FFFF;

  bar_pattern_gen dut (
    .VGA_CLK(clk), .reset(reset), .disp_en(disp_en), .x(x), .y(y),
    .mode_sel(mode_sel), .scroll_en(scroll_en), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] vbar_exp(int p);
    return p < 5 ? BLACK : p < 420 ? RED : p < 425 ? BLACK : p < 840 ? GREEN :
           p < 845 ? BLACK : p < 1260 ? BLUE : BLACK;
  endfunction

  function automatic logic [23:0] hbar_exp(int q);
    return q < 5 ? BLACK : q < 340 ? RED : q < 345 ? BLACK : q < 680 ? GREEN :
           q < 685 ? BLACK : q < 1020 ? BLUE : BLACK;
  endfunction

  task automatic px(input int xv, input int yv, input logic de);
    x = 11'(xv);
    y = 11'(yv);
    disp_en = de;
    @(posedge clk);
    #1;
  endtask

  task automatic boundary(input logic [1:0] m, input logic se);
    mode_sel = m;
    scroll_en = se;
    px(1279, 1023, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    px(7, 10, 1'b1);
    px(8, 10, 1'b1);
    checks++;
    if ({r, g, b} !== BLACK) begin
      errors++;
      $display("FAIL reset rgb got %h want %h", {r, g, b}, BLACK);
    end
    reset = 1'b0;
  endtask

  task automatic test_vbar();
    for (int i = 0; i < 1280; i++) begin
      px(i, 10, 1'b1);
      checks++;
      if ({r, g, b} !== vbar_exp(i)) begin
        errors++;
        $display("FAIL vbar x=%0d got %h want %h", i, {r, g, b}, vbar_exp(i));
      end
    end
  endtask

  task automatic test_blank();
    for (int i = 0; i < 100; i++) px(i, 11, 1'b1);
    px(100, 11, 1'b0);
    checks++;
    if ({r, g, b} !== BLACK) begin
      errors++;
      $display("FAIL blank x=100 got %h want %h", {r, g, b}, BLACK);
    end
    px(101, 11, 1'b1);
    checks++;
    if ({r, g, b} !== RED) begin
      errors++;
      $display("FAIL unblank x=101 got %h want %h", {r, g, b}, RED);
    end
  endtask

  task automatic test_hbar();
    boundary(2'd1, 1'b0);
    for (int j = 0; j < 1024; j++) begin
      px(600, j, 1'b1);
      checks++;
      if ({r, g, b} !== hbar_exp(j)) begin
        errors++;
        $display("FAIL hbar y=%0d got %h want %h", j, {r, g, b}, hbar_exp(j));
      end
    end
  endtask

  task automatic test_scroll();
    logic [23:0] want;
    boundary(2'd3, 1'b1);
    boundary(2'd3, 1'b1);
    boundary(2'd3, 1'b0);
    for (int i = 0; i <= 1255; i++) begin
      px(i, 20, 1'b1);
      if (i inside {0, 411, 412, 417, 1251, 1252, 1255}) begin
        want = (i == 0 || i == 411) ? RED : i == 417 ? GREEN : i == 1251 ? BLUE : BLACK;
        checks++;
        if ({r, g, b} !== want) begin
          errors++;
          $display("FAIL scroll8 x=%0d got %h want %h", i, {r, g, b}, want);
        end
      end
    end
    repeat (313) boundary(2'd3, 1'b1);
    for (int i = 0; i <= 1265; i++) begin
      px(i, 20, 1'b1);
      if (i inside {4, 5, 1259, 1260, 1265}) begin
        want = (i == 5 || i == 1265) ? RED : i == 1259 ? BLUE : BLACK;
        checks++;
        if ({r, g, b} !== want) begin
          errors++;
          $display("FAIL scroll0 x=%0d got %h want %h", i, {r, g, b}, want);
        end
      end
    end
  endtask

  task automatic test_check();
    logic [23:0] want;
    boundary(2'd2, 1'b0);
    for (int j = 0; j <= 2; j++) px(0, j, 1'b1);
    for (int i = 1; i <= 10; i++) px(i, 2, 1'b1);
    checks++;
    if ({r, g, b} !== BLACK) begin
      errors++;
      $display("FAIL check ygap (10,2) got %h want %h", {r, g, b}, BLACK);
    end
    for (int j = 3; j <= 500; j++) px(0, j, 1'b1);
    for (int i = 1; i <= 500; i++) begin
      px(i, 500, 1'b1);
      if (i inside {5, 420, 500}) begin
        want = i == 5 ? GREEN : i == 500 ? BLUE : BLACK;
        checks++;
        if ({r, g, b} !== want) begin
          errors++;
          $display("FAIL check y=500 x=%0d got %h want %h", i, {r, g, b}, want);
        end
      end
    end
    for (int j = 501; j <= 700; j++) px(0, j, 1'b1);
    for (int i = 1; i <= 1265; i++) begin
      px(i, 700, 1'b1);
      if (i inside {5, 845, 1262}) begin
        want = i == 5 ? BLUE : i == 845 ? CYAN : BLACK;
        checks++;
        if ({r, g, b} !== want) begin
          errors++;
          $display("FAIL check y=700 x=%0d got %h want %h", i, {r, g, b}, want);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    boundary(2'd3, 1'b1);
    boundary(2'd0, 1'b0);
    mode_sel = 2'd1;
    for (int i = 0; i <= 300; i++) px(i, 500, 1'b1);
    checks++;
    if ({r, g, b} !== RED) begin
      errors++;
      $display("FAIL midframe mode change (300,500) got %h want %h", {r, g, b}, RED);
    end
    for (int i = 0; i < 300; i++) px(i, 700, 1'b1);
    reset = 1'b1;
    px(300, 700, 1'b1);
    checks++;
    if ({r, g, b} !== BLACK) begin
      errors++;
      $display("FAIL midframe reset got %h want %h", {r, g, b}, BLACK);
    end
    reset = 1'b0;
    for (int i = 301; i < 1280; i++) px(i, 700, 1'b1);
    for (int i = 0; i < 1280; i++) begin
      px(i, 701, 1'b1);
      checks++;
      if ({r, g, b} !== vbar_exp(i)) begin
        errors++;
        $display("FAIL post-reset line x=%0d got %h want %h", i, {r, g, b}, vbar_exp(i));
      end
    end
    boundary(2'd1, 1'b0);
    for (int j = 0; j <= 5; j++) begin
      px(600, j, 1'b1);
      if (j >= 4) begin
        checks++;
        if ({r, g, b} !== (j == 5 ? RED : BLACK)) begin
          errors++;
          $display("FAIL post-reset hbar y=%0d got %h want %h", j, {r, g, b}, j == 5 ? RED : BLACK);
        end
      end
    end
    boundary(2'd3, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      px(i, 20, 1'b1);
      if (i >= 4) begin
        checks++;
        if ({r, g, b} !== (i == 5 ? RED : BLACK)) begin
          errors++;
          $display("FAIL post-reset offset x=%0d got %h want %h", i, {r, g, b}, i == 5 ? RED : BLACK);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vbar();
    test_blank();
    test_hbar();
    test_scroll();
    test_check();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
